// File: rtl/fminmax_reduce_seq.sv
// Streams a vector of FP32 operands through one min/max compare stage and
// holds the reduced result behind a valid/ready output handshake.
module fminmax_reduce_seq #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [2:0]       RM,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_empty
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

  state_t           state;
  logic             is_min;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count;
  logic [31:0]      acc;
  logic [31:0]      sel_result;

  // Raw-bit ordering: sign first, then magnitude (exponent:mantissa),
  // inverted for negatives; -0 lands below +0 through the sign test.
  function automatic logic fp_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31])
      return a[31];
    else if (a[31])
      return a[30:0] > b[30:0];
    else
      return a[30:0] < b[30:0];
  endfunction

  always_comb begin
    sel_result = acc;
    if (is_min) begin
      if (fp_less(in_data, acc)) sel_result = in_data;
    end else begin
      if (!fp_less(in_data, acc)) sel_result = in_data;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign out_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_min    <= 1'b0;
      remaining <= '0;
      count     <= '0;
      acc       <= 32'h0;
      out_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            if (len != '0) begin
              is_min    <= (RM == 3'b000);
              remaining <= (len > MAX_LEN_C) ? MAX_LEN_C : len;
              out_empty <= 1'b0;
              state     <= ACCUM;
            end else begin
              acc       <= 32'h0;
              out_empty <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc       <= (count == '0) ? in_data : sel_result;
            count     <= count + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == 1) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fminmax_reduce_seq.md
Name: fminmax_reduce_seq

Overview:
Sequencer that streams a vector of FP32 operands through a single min/max compare stage and reduces it to one result. It is loaded by a start command carrying the length and the operation. It accepts one element per cycle over a valid/ready input handshake, then holds the result behind a valid/ready output handshake. It sits between the operand fetch path and the writeback stage of the FP unit.

Parameters:
MAX_LEN, 16, maximum vector length; larger requests are clamped to this value.
CNT_W, 5, width of the length and count fields; must satisfy 2^CNT_W > MAX_LEN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  command strobe; sampled only in IDLE.
len  in  CNT_W  number of elements to reduce.
RM  in  3  operation select: 3'b000 = min, any other value = max. Latched at start.
in_valid  in  1  element valid.
in_data  in  32  FP32 element.
in_ready  out  1  element accepted when in_valid & in_ready.
busy  out  1  high in ACCUM and DONE.
out_valid  out  1  result valid.
out_ready  in  1  result consumed when out_valid & out_ready.
out_data  out  32  reduced result.
out_count  out  CNT_W  number of elements actually reduced.
out_empty  out  1  result came from a zero-length request.

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - State goes to IDLE.
  - in_ready=0, busy=0, out_valid=0, out_empty=0.
  - out_data=32'h0, out_count=0; the accumulator and remaining-count register are cleared.
  - Reset takes priority over every other input, including mid-vector and with out_valid pending. Elements already accepted are discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len!=0: latch RM, set remaining = min(len, MAX_LEN), clear the count, go to ACCUM next cycle.
  - start=1 and len==0: go to DONE with out_data=32'h0, out_count=0, out_empty=1.
- ACCUM:
  - in_ready=1 combinationally for the whole state.
  - Per accepted element: count increments, remaining decrements.
  - The first accepted element loads the accumulator directly.
  - Each later element does acc <= select(acc, in_data), where acc is the first operand and in_data the second.
  - When the last element is accepted, the next state is DONE. out_valid rises the cycle after that acceptance, and out_data holds the final accumulator.
  - Cycles with in_valid=0 are stalls; no state changes.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_data, out_count and out_empty are stable until out_valid & out_ready, which returns the FSM to IDLE next cycle.
  - out_data and out_count remain readable in IDLE until the next start; out_valid drops.
- Throughput: one element per cycle. A vector of N elements with no stalls and out_ready=1 occupies N+1 cycles from the first ACCUM cycle to the return to IDLE. start in the same cycle as the IDLE return is accepted.
- start while busy is ignored: no effect on the latched len, RM or accumulator.
- Compare rule (select), pure combinational on raw bits:
  - Different signs: the negative operand is the smaller.
  - Both positive: larger exponent, then larger mantissa, is the greater.
  - Both negative: the ordering is inverted.
  - Equal sign, exponent and mantissa: min returns the first operand and max returns the second. The two are bit-identical, so the result does not depend on the tie choice.
  - -0 (32'h80000000) orders below +0 (32'h00000000).
  - NaN, infinity and denormals get no special handling; they are ordered by the bit fields like any other value.
- Clamp: len > MAX_LEN reduces exactly MAX_LEN elements, and out_count reports MAX_LEN.

Test Plan:
- Max reduction: RM=001, len=4, stream 3F800000, C0000000, 40400000, 3F000000 back-to-back -> out_data=40400000, out_count=4, out_valid rises the cycle after the 4th element is accepted.
- Min reduction with gaps: RM=000, same data with in_valid low on alternate cycles -> out_data=C0000000. in_ready stays 1 during the gaps, and the accumulator is unchanged during the gaps.
- Signed zero and backpressure: RM=000, len=2, stream 00000000, 80000000, hold out_ready=0 for 5 cycles -> out_data=80000000 held stable with out_valid=1 for all 5 cycles; FSM enters IDLE the cycle after out_ready=1.
- Zero length and clamp: len=0 -> out_valid=1, out_empty=1, out_data=0, out_count=0 with no elements accepted. With MAX_LEN=16, len=20 -> in_ready drops after 16 acceptances and out_count=16.
- Start while busy: start pulsed with len=1, RM=000 during an ACCUM of len=3, RM=001 -> ignored; the max result and out_count=3 are unaffected.
- Reset mid-operation: rst=1 after 2 of 4 elements are accepted -> next cycle all outputs are at reset values and the FSM is in IDLE. A fresh start with len=1 and element 41200000 -> out_data=41200000.
